// File: rtl/cg_result_writeback_sequencer.sv
// rtl/cg_result_writeback_sequencer.sv - result-memory writeback sequencer for the CG address control unit.
// Issues credit-limited read_again requests, buffers ALU results, emits ordered result-memory writes.
module cg_result_writeback_sequencer #(
  parameter int no_of_units   = 8,
  parameter int element_width = 32,
  parameter int address_width = 32,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic                                   abort,
  input  logic [31:0]                            total,
  input  logic                                   alu_valid,
  input  logic [no_of_units*element_width-1:0]   alu_data,
  output logic                                   read_again,
  output logic                                   result_mem_we,
  output logic [address_width-1:0]              result_mem_counter,
  output logic [no_of_units*element_width-1:0]   result_mem_data,
  output logic                                   finish_alu,
  output logic                                   busy,
  output logic                                   overflow_err
);
  localparam int word_width = no_of_units * element_width;
  localparam int ptr_width  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int cnt_width  = ptr_width + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state, next_state;
  logic [address_width-1:0] limit, issued, written, in_flight, new_limit;
  logic [word_width-1:0]    fifo_mem [FIFO_DEPTH];
  logic [ptr_width-1:0]     wr_ptr, rd_ptr;
  logic [cnt_width-1:0]     fifo_count;
  logic [address_width:0]   credit_used;
  logic                     accept, req, push, pop, stray;

  assign new_limit   = address_width'(total / 32'(no_of_units));
  // Buffered words plus outstanding requests must always fit in the FIFO.
  assign credit_used = {1'b0, in_flight} + (address_width+1)'(fifo_count);

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    req        = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    stray      = 1'b0;
    case (state)
      IDLE: begin
        accept = start && !abort;
        if (accept) next_state = (new_limit == '0) ? DONE : RUN;
      end
      RUN: begin
        req  = (issued < limit) && (credit_used < (address_width+1)'(FIFO_DEPTH));
        push = alu_valid && (in_flight != '0);
        pop  = (fifo_count != '0);
        if (pop && (written == limit - address_width'(1))) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    stray = alu_valid && !push;
    if (abort) begin
      next_state = IDLE;
      req        = 1'b0;
      push       = 1'b0;
      pop        = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      limit              <= '0;
      issued             <= '0;
      written            <= '0;
      in_flight          <= '0;
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      fifo_count         <= '0;
      read_again         <= 1'b0;
      result_mem_we      <= 1'b0;
      result_mem_counter <= '0;
      result_mem_data    <= '0;
      finish_alu         <= 1'b0;
      busy               <= 1'b0;
      overflow_err       <= 1'b0;
    end else begin
      state         <= next_state;
      read_again    <= req;
      result_mem_we <= pop;
      finish_alu    <= (state == DONE) && !abort;
      busy          <= (next_state != IDLE);
      overflow_err  <= overflow_err | stray;
      if (accept) begin
        limit   <= new_limit;
        issued  <= '0;
        written <= '0;
      end
      if (req) issued <= issued + address_width'(1);
      if (pop) begin
        result_mem_data    <= fifo_mem[rd_ptr];
        result_mem_counter <= written;
        written            <= written + address_width'(1);
      end else if (next_state == IDLE) begin
        result_mem_counter <= '0;
      end
      if (abort || accept) begin
        in_flight  <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
      end else begin
        in_flight  <= in_flight + address_width'(req) - address_width'(push);
        fifo_count <= fifo_count + cnt_width'(push) - cnt_width'(pop);
        if (push) wr_ptr <= wr_ptr + ptr_width'(1);
        if (pop)  rd_ptr <= rd_ptr + ptr_width'(1);
      end
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= alu_data;
  end
endmodule

// File: tb/tb_cg_result_writeback_sequencer.sv
// tb/tb_cg_result_writeback_sequencer.sv - self-checking bench for cg_result_writeback_sequencer.
// A latency-programmable ALU echo feeds the DUT; writes are checked against the ordered response stream.
module tb_cg_result_writeback_sequencer;
  localparam int NU = 8, EW = 32, AW = 32, FD = 4, WW = NU * EW;

  logic          clk = 1'b0;
  logic          reset, start, abort, alu_valid;
  logic [31:0]   total;
  logic [WW-1:0] alu_data;
  logic          read_again, result_mem_we, finish_alu, busy, overflow_err;
  logic [AW-1:0] result_mem_counter;
  logic [WW-1:0] result_mem_data;

  cg_result_writeback_sequencer #(
    .no_of_units(NU), .element_width(EW), .address_width(AW), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .total(total),
    .alu_valid(alu_valid), .alu_data(alu_data), .read_again(read_again),
    .result_mem_we(result_mem_we), .result_mem_counter(result_mem_counter),
    .result_mem_data(result_mem_data), .finish_alu(finish_alu), .busy(busy),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  int            n_checks = 0, n_errors = 0, cyc = 0, latency = 0;
  int            resp_t[$];
  logic [WW-1:0] resp_d[$];
  logic [WW-1:0] exp_q[$];
  int            n_req, n_wr, n_fin, n_resp, max_out, wr_idx, fin_cyc, last_wr_cyc, post_evt;
  bit            alu_mute, post_abort, busy_before_fin;
  logic          prev_busy;

  task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs == exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [WW-1:0] rand_word();
    logic [WW-1:0] w;
    for (int i = 0; i < NU; i++) w[i*EW +: EW] = $urandom;
    return w;
  endfunction

  // One clock: observe at the falling edge, then drive the ALU response for the next rising edge.
  task automatic cycle();
    logic [WW-1:0] e;
    @(negedge clk);
    cyc++;
    if (read_again) begin
      n_req++;
      resp_t.push_back(cyc + latency);
      resp_d.push_back(rand_word());
    end
    if (n_req - n_resp > max_out) max_out = n_req - n_resp;
    if (result_mem_we) begin
      n_wr++;
      last_wr_cyc = cyc;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : {WW{1'bx}};
      check("wr_counter", WW'(result_mem_counter), WW'(wr_idx));
      check("wr_data", result_mem_data, e);
      wr_idx++;
    end
    if (finish_alu) begin
      n_fin++;
      fin_cyc = cyc;
      busy_before_fin = prev_busy;
      check("busy_low_with_finish", WW'(busy), WW'(0));
    end
    if (post_abort) post_evt += int'(read_again) + int'(result_mem_we) + int'(finish_alu);
    prev_busy = busy;
    if (!alu_mute && resp_t.size() != 0 && resp_t[0] <= cyc) begin
      resp_t.delete(0);
      alu_data  = resp_d.pop_front();
      alu_valid = 1'b1;
      exp_q.push_back(alu_data);
      n_resp++;
    end else begin
      alu_valid = 1'b0;
    end
  endtask

  task automatic run_pass(input int tot, input int lat, input int poke, input int abort_after,
                          input logic exp_ovf);
    int lim, k, start_cyc, post_n;
    bit done, aborted;
    lim = tot / NU;
    latency = lat;
    n_req = 0; n_wr = 0; n_fin = 0; n_resp = 0; max_out = 0; wr_idx = 0;
    fin_cyc = -1; last_wr_cyc = -1; post_evt = 0; post_abort = 0; busy_before_fin = 0;
    resp_t.delete(); resp_d.delete(); exp_q.delete(); alu_mute = 0;
    start = 1'b1; total = tot; start_cyc = cyc;
    cycle();
    start = 1'b0; total = $urandom;
    check("busy_after_start", WW'(busy), WW'(1));
    done = 0; aborted = 0; post_n = 0; k = 0;
    while (!done && k < 600) begin
      k++;
      start = (k == poke);
      if (k == poke) total = 32'd800;
      cycle();
      if (abort) abort = 1'b0;
      else if (!aborted && abort_after >= 0 && n_wr == abort_after) begin
        abort = 1'b1; alu_mute = 1; aborted = 1; post_abort = 1;
        resp_t.delete(); resp_d.delete(); exp_q.delete();
      end
      if (post_abort) post_n++;
      done = (n_fin > 0) || (post_n >= 12);
    end
    start = 1'b0;
    check_int("pass_completed_in_budget", int'(done), 1);
    repeat (3) cycle();
    if (abort_after < 0) begin
      check_int("finish_count", n_fin, 1);
      check_int("read_again_count", n_req, lim);
      check_int("write_count", n_wr, lim);
      check_int("busy_high_before_finish", int'(busy_before_fin), 1);
      check_int("outstanding_within_depth", int'(max_out <= FD), 1);
      check_int("responses_all_written", exp_q.size(), 0);
      if (lim == 0) check_int("finish_latency_limit0", fin_cyc - start_cyc, 2);
      else          check_int("finish_after_last_write", fin_cyc - last_wr_cyc, 1);
    end else begin
      check_int("writes_before_abort", n_wr, abort_after);
      check_int("no_finish_after_abort", n_fin, 0);
      check_int("silent_after_abort", post_evt, 0);
    end
    post_abort = 0;
    check("overflow_err", WW'(overflow_err), WW'(exp_ovf));
    check("busy_idle", WW'(busy), WW'(0));
    check("counter_idle", WW'(result_mem_counter), WW'(0));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; total = '0; alu_valid = 1'b0; alu_data = '0;
    alu_mute = 0; post_abort = 0; prev_busy = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_read_again", WW'(read_again), WW'(0));
    check("reset_we", WW'(result_mem_we), WW'(0));
    check("reset_counter", WW'(result_mem_counter), WW'(0));
    check("reset_data", result_mem_data, WW'(0));
    check("reset_finish", WW'(finish_alu), WW'(0));
    check("reset_busy", WW'(busy), WW'(0));
    check("reset_overflow", WW'(overflow_err), WW'(0));
    reset = 1'b0;

    run_pass(64, 0, -1, -1, 1'b0);
    run_pass(64, 10, -1, -1, 1'b0);
    run_pass(7, 0, -1, -1, 1'b0);

    alu_valid = 1'b1; alu_data = rand_word(); n_wr = 0;
    cycle();
    check("overflow_after_spurious", WW'(overflow_err), WW'(1));
    cycle();
    check_int("no_write_from_spurious", n_wr, 0);
    run_pass(16, 2, -1, -1, 1'b1);

    run_pass(64, 0, -1, 3, 1'b1);
    run_pass(64, 1, -1, -1, 1'b1);
    run_pass(32, 3, 2, -1, 1'b1);

    resp_t.delete(); resp_d.delete(); exp_q.delete(); alu_mute = 0; latency = 10;
    n_req = 0; n_resp = 0; wr_idx = 0;
    start = 1'b1; total = 32'd64;
    cycle();
    start = 1'b0;
    repeat (8) cycle();
    start = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("async_reset_read_again", WW'(read_again), WW'(0));
    check("async_reset_we", WW'(result_mem_we), WW'(0));
    check("async_reset_busy", WW'(busy), WW'(0));
    check("async_reset_overflow", WW'(overflow_err), WW'(0));
    check("async_reset_counter", WW'(result_mem_counter), WW'(0));
    alu_mute = 1; resp_t.delete(); resp_d.delete(); exp_q.delete();
    start = 1'b0;
    repeat (2) cycle();
    reset = 1'b0; n_wr = 0; n_req = 0; n_fin = 0;
    repeat (4) cycle();
    check_int("post_reset_no_writes", n_wr + n_req + n_fin, 0);
    check("post_reset_busy", WW'(busy), WW'(0));
    run_pass(64, 0, -1, -1, 1'b0);

    for (int i = 0; i < 6; i++) run_pass($urandom_range(0, 120), $urandom_range(0, 7), -1, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
